// File: rtl/operation_control_word_2_rotator.sv
// In-service register with OCW2 EOI / rotation command handling for an 8259-style controller.
// Optional feature macro: OCW2_AUTO_EOI_EN enables auto-EOI clearing on the last INTA strobe.
`timescale 1ns/1ps

module operation_control_word_2_rotator #(
   parameter int NUM_LEVELS = 8,
   parameter int LEVEL_W    = $clog2(NUM_LEVELS)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  write_initial_command_word_1,
   input  logic                  auto_eoi_config,
   input  logic                  write_operation_control_word_2,
   input  logic [7:0]            internal_data_bus,
   input  logic [LEVEL_W-1:0]    level_select,
   input  logic                  acknowledge_set,
   input  logic [NUM_LEVELS-1:0] acknowledge_interrupt,
   input  logic                  end_of_acknowledge_sequence,
   output logic [NUM_LEVELS-1:0] in_service_register,
   output logic [NUM_LEVELS-1:0] highest_level_in_service,
   output logic [NUM_LEVELS-1:0] end_of_interrupt,
   output logic                  auto_rotate_mode,
   output logic [LEVEL_W-1:0]    priority_rotate,
   output logic                  eoi_error
);

   localparam logic [2:0] CMD_SET_PRIORITY = 3'b110;

   logic [NUM_LEVELS-1:0] r_isr;
   logic [NUM_LEVELS-1:0] r_eoi;
   logic                  r_arm;
   logic                  r_err;
   logic [LEVEL_W-1:0]    r_rot;

   logic [2:0]            w_cmd;
   logic [NUM_LEVELS-1:0] w_highest;
   logic [NUM_LEVELS-1:0] w_set;
   logic [NUM_LEVELS-1:0] w_sel_onehot;
   logic [NUM_LEVELS-1:0] w_target;
   logic [LEVEL_W-1:0]    w_target_idx;
   logic [NUM_LEVELS-1:0] w_clear;
   logic                  w_err;
   logic                  w_rot_load;
   logic [LEVEL_W-1:0]    w_rot_next;
   logic                  w_mode_wr;
   logic                  w_auto_eoi;
   logic                  w_unused;

   function automatic logic [LEVEL_W-1:0] f_level_of(input logic [NUM_LEVELS-1:0] v);
      f_level_of = '0;
      for (int i = 0; i < NUM_LEVELS; i++) begin
         if (v[i]) f_level_of = LEVEL_W'(i);
      end
   endfunction

`ifdef OCW2_AUTO_EOI_EN
   assign w_auto_eoi = auto_eoi_config & end_of_acknowledge_sequence;
   assign w_unused   = ^internal_data_bus[4:0];
`else
   assign w_auto_eoi = 1'b0;
   assign w_unused   = ^{internal_data_bus[4:0], auto_eoi_config, end_of_acknowledge_sequence};
`endif

   // Scan from the level just above the lowest-priority one; the index wraps naturally
   // because NUM_LEVELS is a power of two.
   always_comb begin
      logic [LEVEL_W-1:0] idx;
      logic               found;
      w_highest = '0;
      found     = 1'b0;
      idx       = '0;
      for (int i = 1; i <= NUM_LEVELS; i++) begin
         idx = r_rot + LEVEL_W'(i);
         if (!found && r_isr[idx]) begin
            w_highest[idx] = 1'b1;
            found          = 1'b1;
         end
      end
   end

   assign w_cmd        = internal_data_bus[7:5];
   assign w_set        = acknowledge_set ? acknowledge_interrupt : '0;
   assign w_sel_onehot = {{(NUM_LEVELS-1){1'b0}}, 1'b1} << level_select;
   assign w_target     = w_cmd[1] ? w_sel_onehot : w_highest;
   assign w_target_idx = w_cmd[1] ? level_select : f_level_of(w_highest);
   assign w_mode_wr    = write_operation_control_word_2 && (w_cmd[1:0] == 2'b00);

   // Auto-EOI owns the clear/rotate path for the cycle; a concurrent OCW2 EOI, rotate or
   // set-priority is dropped, while auto-rotate mode writes still land.
   always_comb begin
      w_clear    = '0;
      w_err      = 1'b0;
      w_rot_load = 1'b0;
      w_rot_next = r_rot;
      if (w_auto_eoi) begin
         w_clear = acknowledge_interrupt;
         if (r_arm && (|acknowledge_interrupt)) begin
            w_rot_load = 1'b1;
            w_rot_next = f_level_of(acknowledge_interrupt);
         end
      end else if (write_operation_control_word_2) begin
         if (w_cmd == CMD_SET_PRIORITY) begin
            w_rot_load = 1'b1;
            w_rot_next = level_select;
         end else if (w_cmd[0]) begin
            if ((w_target & r_isr) == '0) begin
               w_err = 1'b1;
            end else begin
               w_clear = w_target;
               if (w_cmd[2]) begin
                  w_rot_load = 1'b1;
                  w_rot_next = w_target_idx;
               end
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset || write_initial_command_word_1) begin
         r_isr <= '0;
         r_eoi <= '0;
         r_err <= 1'b0;
         r_arm <= 1'b0;
         r_rot <= LEVEL_W'(NUM_LEVELS - 1);
      end else begin
         r_isr <= (r_isr & ~w_clear) | w_set;
         r_eoi <= w_clear;
         r_err <= w_err;
         if (w_rot_load) r_rot <= w_rot_next;
         if (w_mode_wr)  r_arm <= w_cmd[2];
      end
   end

   assign in_service_register      = r_isr;
   assign highest_level_in_service = w_highest;
   assign end_of_interrupt         = r_eoi;
   assign auto_rotate_mode         = r_arm;
   assign priority_rotate          = r_rot;
   assign eoi_error                = r_err;

endmodule

// File: tb/tb_operation_control_word_2_rotator.sv
// Bench for operation_control_word_2_rotator: vector table, hand sequences, and random
// stimulus against a behavioural model of the priority/EOI rules.
`timescale 1ns/1ps

module tb_operation_control_word_2_rotator;

   typedef struct {
      logic       rst, icw1, ocw2;
      logic [7:0] bus;
      logic [2:0] lvl;
      logic       ackset;
      logic [7:0] ackint;
      logic       eoas, aeoi;
   } stim_t;

   typedef struct {
      stim_t      s;
      logic [7:0] e_isr, e_hi, e_eoi;
      logic       e_arm;
      logic [2:0] e_rot;
      logic       e_err;
   } vec_t;

`ifdef OCW2_AUTO_EOI_EN
   localparam bit AEOI_EN = 1'b1;
`else
   localparam bit AEOI_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // 8-level instance
   logic       rst = 1'b0, icw1 = 1'b0, aeoi = 1'b0, ocw2 = 1'b0, ackset = 1'b0, eoas = 1'b0;
   logic [7:0] bus = '0, ackint = '0;
   logic [2:0] lvl = '0;
   logic [7:0] isr, hi, eoi;
   logic       arm, err;
   logic [2:0] rot;

   operation_control_word_2_rotator #(.NUM_LEVELS(8)) u_dut (
      .clock(clk), .reset(rst), .write_initial_command_word_1(icw1),
      .auto_eoi_config(aeoi), .write_operation_control_word_2(ocw2),
      .internal_data_bus(bus), .level_select(lvl), .acknowledge_set(ackset),
      .acknowledge_interrupt(ackint), .end_of_acknowledge_sequence(eoas),
      .in_service_register(isr), .highest_level_in_service(hi),
      .end_of_interrupt(eoi), .auto_rotate_mode(arm), .priority_rotate(rot),
      .eoi_error(err)
   );

   // 16-level instance
   logic        rst16 = 1'b1, icw1_16 = 1'b0, aeoi16 = 1'b0, ocw2_16 = 1'b0;
   logic        ackset16 = 1'b0, eoas16 = 1'b0;
   logic [7:0]  bus16 = '0;
   logic [3:0]  lvl16 = '0;
   logic [15:0] ackint16 = '0;
   logic [15:0] isr16, hi16, eoi16;
   logic        arm16, err16;
   logic [3:0]  rot16;

   operation_control_word_2_rotator #(.NUM_LEVELS(16)) u_dut16 (
      .clock(clk), .reset(rst16), .write_initial_command_word_1(icw1_16),
      .auto_eoi_config(aeoi16), .write_operation_control_word_2(ocw2_16),
      .internal_data_bus(bus16), .level_select(lvl16), .acknowledge_set(ackset16),
      .acknowledge_interrupt(ackint16), .end_of_acknowledge_sequence(eoas16),
      .in_service_register(isr16), .highest_level_in_service(hi16),
      .end_of_interrupt(eoi16), .auto_rotate_mode(arm16), .priority_rotate(rot16),
      .eoi_error(err16)
   );

   // Behavioural model state (8 levels)
   bit [7:0] m_isr, m_eoi;
   bit       m_arm, m_err;
   int       m_rot;

   function automatic int m_highest(input bit [7:0] v, input int r);
      for (int k = 1; k <= 8; k++) begin
         if (v[(r + k) % 8]) return (r + k) % 8;
      end
      return -1;
   endfunction

   function automatic int m_level(input bit [7:0] v);
      for (int k = 0; k < 8; k++) if (v[k]) return k;
      return -1;
   endfunction

   task automatic model_step(input stim_t s);
      bit [7:0] clr;
      bit       e;
      bit       auto_ev;
      int       tgt;
      if (s.rst || s.icw1) begin
         m_isr = '0; m_eoi = '0; m_err = 1'b0; m_arm = 1'b0; m_rot = 7;
         return;
      end
      clr = '0;
      e = 1'b0;
      auto_ev = AEOI_EN && s.aeoi && s.eoas;
      if (auto_ev) begin
         clr = s.ackint;
         if (m_arm && s.ackint != 0) m_rot = m_level(s.ackint);
      end
      if (s.ocw2) begin
         case (s.bus[7:5])
            3'b100: m_arm = 1'b1;
            3'b000: m_arm = 1'b0;
            3'b010: ;
            3'b110: if (!auto_ev) m_rot = int'(s.lvl);
            default: if (!auto_ev) begin
               tgt = s.bus[6] ? int'(s.lvl) : m_highest(m_isr, m_rot);
               if (tgt < 0 || !m_isr[tgt]) e = 1'b1;
               else begin
                  clr[tgt] = 1'b1;
                  if (s.bus[7]) m_rot = tgt;
               end
            end
         endcase
      end
      m_isr = (m_isr & ~clr) | (s.ackset ? s.ackint : 8'h00);
      m_eoi = clr;
      m_err = e;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [7:0] e_isr, input logic [7:0] e_hi,
                            input logic [7:0] e_eoi, input logic e_arm, input logic [2:0] e_rot,
                            input logic e_err);
      check({tag, " isr"},  32'(isr), 32'(e_isr));
      check({tag, " hi"},   32'(hi),  32'(e_hi));
      check({tag, " eoi"},  32'(eoi), 32'(e_eoi));
      check({tag, " arm"},  32'(arm), 32'(e_arm));
      check({tag, " rot"},  32'(rot), 32'(e_rot));
      check({tag, " err"},  32'(err), 32'(e_err));
   endtask

   function automatic stim_t mks(input int r, input int i1, input int o2, input int b,
                                 input int l, input int as, input int ai,
                                 input int eo, input int ae);
      stim_t s;
      s.rst = 1'(r); s.icw1 = 1'(i1); s.ocw2 = 1'(o2); s.bus = 8'(b); s.lvl = 3'(l);
      s.ackset = 1'(as); s.ackint = 8'(ai); s.eoas = 1'(eo); s.aeoi = 1'(ae);
      return s;
   endfunction

   function automatic vec_t mkv(input stim_t s, input int ei, input int eh, input int ee,
                                input int ea, input int er, input int ex);
      vec_t v;
      v.s = s; v.e_isr = 8'(ei); v.e_hi = 8'(eh); v.e_eoi = 8'(ee);
      v.e_arm = 1'(ea); v.e_rot = 3'(er); v.e_err = 1'(ex);
      return v;
   endfunction

   task automatic apply(input stim_t s);
      rst = s.rst; icw1 = s.icw1; ocw2 = s.ocw2; bus = s.bus; lvl = s.lvl;
      ackset = s.ackset; ackint = s.ackint; eoas = s.eoas; aeoi = s.aeoi;
      @(posedge clk);
      #1;
   endtask

   task automatic step16(input int r, input int i1, input int o2, input int b, input int l,
                         input int as, input int ai);
      rst16 = 1'(r); icw1_16 = 1'(i1); ocw2_16 = 1'(o2); bus16 = 8'(b); lvl16 = 4'(l);
      ackset16 = 1'(as); ackint16 = 16'(ai);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, 0 of 1 expected");
      $fatal(1);
   end

   initial begin
      vec_t  tbl[$];
      stim_t s;

      // rst icw1 ocw2 bus lvl ackset ackint eoas aeoi -> isr hi eoi arm rot err
      tbl.push_back(mkv(mks(1,0,0,'h00,0,0,'h00,0,0), 'h00,'h00,'h00,0,7,0));
      tbl.push_back(mkv(mks(0,0,0,'h00,0,1,'h08,0,0), 'h08,'h08,'h00,0,7,0));
      tbl.push_back(mkv(mks(0,0,0,'h00,0,1,'h20,0,0), 'h28,'h08,'h00,0,7,0));
      tbl.push_back(mkv(mks(0,0,1,'h20,0,0,'h00,0,0), 'h20,'h20,'h08,0,7,0));
      tbl.push_back(mkv(mks(0,0,0,'h00,0,0,'h00,0,0), 'h20,'h20,'h00,0,7,0));
      tbl.push_back(mkv(mks(0,0,1,'hC0,4,0,'h00,0,0), 'h20,'h20,'h00,0,4,0));
      tbl.push_back(mkv(mks(0,0,0,'h00,0,1,'h01,0,0), 'h21,'h20,'h00,0,4,0));
      tbl.push_back(mkv(mks(0,0,1,'h60,5,0,'h00,0,0), 'h01,'h01,'h20,0,4,0));
      tbl.push_back(mkv(mks(0,0,1,'h60,5,0,'h00,0,0), 'h01,'h01,'h00,0,4,1));
      tbl.push_back(mkv(mks(0,0,0,'h00,0,0,'h00,0,0), 'h01,'h01,'h00,0,4,0));
      tbl.push_back(mkv(mks(0,0,1,'h20,0,0,'h00,0,0), 'h00,'h00,'h01,0,4,0));
      tbl.push_back(mkv(mks(0,0,1,'h20,0,0,'h00,0,0), 'h00,'h00,'h00,0,4,1));
      tbl.push_back(mkv(mks(0,0,0,'h00,0,1,'h04,0,0), 'h04,'h04,'h00,0,4,0));
      tbl.push_back(mkv(mks(0,0,1,'hE0,2,0,'h00,0,0), 'h00,'h00,'h04,0,2,0));
      tbl.push_back(mkv(mks(0,0,1,'h80,0,0,'h00,0,0), 'h00,'h00,'h00,1,2,0));
      tbl.push_back(mkv(mks(0,0,1,'hA0,0,1,'h02,0,0), 'h02,'h02,'h00,1,2,1));
      tbl.push_back(mkv(mks(0,0,1,'hA0,0,0,'h00,0,0), 'h00,'h00,'h02,1,1,0));
      tbl.push_back(mkv(mks(0,0,1,'h60,6,1,'h40,0,0), 'h40,'h40,'h00,1,1,1));
      tbl.push_back(mkv(mks(0,0,1,'h60,6,1,'h40,0,0), 'h40,'h40,'h40,1,1,0));
      tbl.push_back(mkv(mks(0,0,1,'h00,0,0,'h00,0,0), 'h40,'h40,'h00,0,1,0));
      tbl.push_back(mkv(mks(0,1,0,'h00,0,1,'hFF,0,0), 'h00,'h00,'h00,0,7,0));
      tbl.push_back(mkv(mks(0,0,1,'h40,3,0,'h00,0,0), 'h00,'h00,'h00,0,7,0));
      tbl.push_back(mkv(mks(0,0,1,'hC0,6,0,'h00,0,0), 'h00,'h00,'h00,0,6,0));
      tbl.push_back(mkv(mks(0,0,0,'h00,0,1,'h81,0,0), 'h81,'h80,'h00,0,6,0));
      tbl.push_back(mkv(mks(0,0,1,'hA0,0,0,'h00,0,0), 'h01,'h01,'h80,0,7,0));

      foreach (tbl[i]) begin
         apply(tbl[i].s);
         check_all($sformatf("vec%0d", i), tbl[i].e_isr, tbl[i].e_hi, tbl[i].e_eoi,
                   tbl[i].e_arm, tbl[i].e_rot, tbl[i].e_err);
      end

      // Reset and ICW1 arriving with other strobes discard them.
      apply(mks(1,0,0,'h00,0,0,'h00,0,0));
      apply(mks(0,0,0,'h00,0,1,'h10,0,0));
      check_all("pre_rst", 'h10, 'h10, 'h00, 0, 7, 0);
      apply(mks(1,0,1,'h80,0,1,'h08,1,1));
      check_all("rst_mid", 'h00, 'h00, 'h00, 0, 7, 0);
      apply(mks(0,0,1,'hC0,2,1,'h20,0,0));
      apply(mks(0,1,1,'h80,0,1,'h08,1,1));
      check_all("icw1_mid", 'h00, 'h00, 'h00, 0, 7, 0);

      // Auto-EOI event racing a specific EOI on another level.
      apply(mks(1,0,0,'h00,0,0,'h00,0,0));
      apply(mks(0,0,0,'h00,0,1,'h02,0,0));
      apply(mks(0,0,1,'hC0,3,0,'h00,0,0));
      apply(mks(0,0,1,'h80,0,0,'h00,0,0));
      apply(mks(0,0,0,'h00,0,1,'h80,0,0));
      check_all("aeoi_pre", 'h82, 'h80, 'h00, 1, 3, 0);
      apply(mks(0,0,1,'h60,1,0,'h80,1,1));
`ifdef OCW2_AUTO_EOI_EN
      check_all("aeoi_evt", 'h02, 'h02, 'h80, 1, 7, 0);
`else
      check_all("aeoi_off", 'h80, 'h80, 'h02, 1, 3, 0);
`endif

      // Randomized run against the model.
      apply(mks(1,0,0,'h00,0,0,'h00,0,0));
      model_step(mks(1,0,0,'h00,0,0,'h00,0,0));
      for (int n = 0; n < 2000; n++) begin
         s.rst    = ($urandom_range(0, 49) == 0);
         s.icw1   = ($urandom_range(0, 39) == 0);
         s.ocw2   = ($urandom_range(0, 2) == 0);
         s.bus    = 8'($urandom);
         s.lvl    = 3'($urandom);
         s.ackset = ($urandom_range(0, 2) == 0);
         s.ackint = 8'(1) << $urandom_range(0, 7);
         s.eoas   = ($urandom_range(0, 3) == 0);
         s.aeoi   = 1'($urandom_range(0, 1));
         apply(s);
         model_step(s);
         check_all($sformatf("rnd%0d", n), m_isr, 8'(m_highest(m_isr, m_rot) < 0 ? 0 :
                   (1 << m_highest(m_isr, m_rot))), m_eoi, m_arm, 3'(m_rot), m_err);
      end
      apply(mks(0,0,0,'h00,0,0,'h00,0,0));

      // 16-level instance: wraparound priority and ICW1 mid-stream.
      step16(1,0,0,'h00,0,0,'h0000);
      check("l16 rst rot", 32'(rot16), 32'd15);
      step16(0,0,0,'h00,0,1,'h0001);
      step16(0,0,0,'h00,0,1,'h8000);
      check("l16 isr", 32'(isr16), 32'h8001);
      check("l16 hi rot15", 32'(hi16), 32'h0001);
      step16(0,0,1,'hC0,14,0,'h0000);
      check("l16 rot", 32'(rot16), 32'd14);
      check("l16 hi rot14", 32'(hi16), 32'h8000);
      step16(0,1,0,'h00,0,1,'h0100);
      check("l16 icw1 isr", 32'(isr16), 32'h0000);
      check("l16 icw1 rot", 32'(rot16), 32'd15);
      check("l16 icw1 hi", 32'(hi16), 32'h0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/operation_control_word_2_rotator.md
OPERATION_CONTROL_WORD_2_ROTATOR -- requirements
Module: operation_control_word_2_rotator

Interface
REQ-001 Parameter NUM_LEVELS, default 8, meaning interrupt level count; SHALL be a power of two, 4..32.
REQ-002 Parameter LEVEL_W, default $clog2(NUM_LEVELS), meaning level-number width; SHALL be derived, never overridden.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 write_initial_command_word_1  in  1  ICW1 write strobe, one cycle.
REQ-006 auto_eoi_config  in  1  auto-EOI mode from ICW4.
REQ-007 write_operation_control_word_2  in  1  OCW2 write strobe, one cycle.
REQ-008 internal_data_bus  in  8  OCW2 byte; bits [7:5] command.
REQ-009 level_select  in  LEVEL_W  level operand for specific-EOI and set-priority commands.
REQ-010 acknowledge_set  in  1  first-INTA strobe; sets the ISR bit given by acknowledge_interrupt.
REQ-011 acknowledge_interrupt  in  NUM_LEVELS  one-hot level being acknowledged.
REQ-012 end_of_acknowledge_sequence  in  1  last-INTA strobe.
REQ-013 in_service_register  out  NUM_LEVELS  registered ISR.
REQ-014 highest_level_in_service  out  NUM_LEVELS  one-hot highest-priority set ISR bit under current rotation; zero if ISR empty; combinational from registers.
REQ-015 end_of_interrupt  out  NUM_LEVELS  registered one-cycle pulse of bits cleared.
REQ-016 auto_rotate_mode  out  1  registered auto-rotate state.
REQ-017 priority_rotate  out  LEVEL_W  registered lowest-priority level.
REQ-018 eoi_error  out  1  registered one-cycle pulse: EOI with nothing to clear.

Function
REQ-019 Priority order SHALL be priority_rotate+1 (highest) upward modulo NUM_LEVELS to priority_rotate (lowest).
REQ-020 OCW2 commands [7:5]: 001 non-specific EOI, 011 specific EOI, 101 rotate on non-specific EOI, 111 rotate on specific EOI, 100 set auto-rotate, 000 clear auto-rotate, 110 set priority, 010 no-op.
REQ-021 Non-specific EOI SHALL clear highest_level_in_service; specific EOI SHALL clear bit level_select.
REQ-022 Rotate commands SHALL also load priority_rotate with the cleared level's number; 110 SHALL load level_select without touching ISR.
REQ-023 acknowledge_set SHALL OR acknowledge_interrupt into ISR next cycle.
REQ-024 Auto-EOI event (auto_eoi_config & end_of_acknowledge_sequence) SHALL clear the acknowledge_interrupt bit; if auto_rotate_mode, priority_rotate SHALL load that level's number.
REQ-025 Precedence per cycle: reset > ICW1 > auto-EOI event > OCW2 EOI/rotate; a concurrent lower-priority EOI/rotate SHALL be dropped; 100/000 mode writes SHALL still apply.
REQ-026 ISR next = (ISR & ~clear) | set; same-bit set and clear SHALL leave the bit set.
REQ-027 end_of_interrupt SHALL equal the clear vector one cycle after the event, zero otherwise; latency exactly one cycle.
REQ-028 eoi_error SHALL pulse when a non-specific EOI finds ISR empty or a specific EOI targets a clear bit; ISR and priority_rotate SHALL then be unchanged.
REQ-029 Rotation arithmetic SHALL wrap modulo NUM_LEVELS; level NUM_LEVELS-1 +1 = 0.

Reset
REQ-030 reset or ICW1 SHALL set ISR=0, end_of_interrupt=0, eoi_error=0, auto_rotate_mode=0, priority_rotate=NUM_LEVELS-1.
REQ-031 reset mid-sequence SHALL discard all concurrent strobes that cycle.

Configuration
REQ-032 Macro OCW2_AUTO_EOI_EN defined: REQ-024 active.
REQ-033 Macro OCW2_AUTO_EOI_EN undefined: auto_eoi_config ignored, no auto-EOI clears or auto-rotations; OCW2 path unaffected.

Verification
REQ-034 reset; ack levels 3,5 -> ISR=0x28, highest=0x08; OCW2 0x20 -> end_of_interrupt=0x08 one cycle, ISR=0x20.
REQ-035 OCW2 0xC0 level_select=4 -> priority_rotate=4; ISR=0x21 -> highest=0x20 (level 5 beats 0).
REQ-036 ISR=0x04, OCW2 0xE0 level_select=2 -> ISR=0, priority_rotate=2, eoi_error=0.
REQ-037 ISR=0, OCW2 0x20 -> eoi_error=1 one cycle, end_of_interrupt=0, priority_rotate unchanged.
REQ-038 OCW2_AUTO_EOI_EN, auto_eoi_config=1, auto-rotate set, ack level 7 then end_of_acknowledge_sequence with concurrent OCW2 0x60 level 1 -> end_of_interrupt=0x80, priority_rotate=7, bit 1 untouched.
REQ-039 NUM_LEVELS=16: ISR=0x8001, priority_rotate=14 -> highest=0x8000; ICW1 mid-stream -> ISR=0, priority_rotate=15.
